// File: rtl/gray_sync_decoder.sv
// Synchronizes a foreign-domain Gray count, decodes it and reports the advance.
// Define GRAY_SYNC_DECODER_ERRCHECK_EN to compile in the sticky Gray-step checker.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_gray,
  input  logic             i_errorClear,
  output logic [WIDTH-1:0] o_binary,
  output logic [WIDTH-1:0] o_delta,
  output logic             o_changed,
  output logic             o_ready,
  output logic             o_error
);

  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] bin;

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             changed_q, changed_d;
  logic             ready_q, ready_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_gray};
    end
  end

  assign g = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of the Gray bits at and above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(g >> i);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = PRIME;
        end
      end
      PRIME:   state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    bin_d     = bin_q;
    delta_d   = delta_q;
    changed_d = changed_q;
    ready_d   = ready_q;
    unique case (state_q)
      PRIME: begin
        bin_d     = bin;
        delta_d   = '0;
        changed_d = 1'b0;
      end
      RUN: begin
        bin_d     = bin;
        delta_d   = bin - bin_q;
        changed_d = (bin != bin_q);
        ready_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      bin_q     <= '0;
      delta_q   <= '0;
      changed_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      delta_q   <= delta_d;
      changed_q <= changed_d;
      ready_q   <= ready_d;
    end
  end

  assign o_binary  = bin_q;
  assign o_delta   = delta_q;
  assign o_changed = changed_q;
  assign o_ready   = ready_q;

`ifdef GRAY_SYNC_DECODER_ERRCHECK_EN
  logic [WIDTH-1:0] gp_q, gp_d;
  logic [WIDTH-1:0] diff;
  logic             multi;
  logic             err_q, err_d;

  // More than one set bit iff clearing the lowest one leaves something.
  assign diff  = g ^ gp_q;
  assign multi = (diff & (diff - 1'b1)) != '0;

  always_comb begin
    gp_d  = (state_q == FILL) ? gp_q : g;
    err_d = ((state_q == RUN) && multi) || (err_q && !i_errorClear);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      gp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      gp_q  <= gp_d;
      err_q <= err_d;
    end
  end

  assign o_error = err_q;
`else
  logic unused_clr;
  assign unused_clr = i_errorClear;
  assign o_error    = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Randomized bench for gray_sync_decoder: a 4-bit/2-stage and an 8-bit/3-stage
// instance checked against a per-edge history model of the sent counts.
module tb_gray_sync_decoder;

  localparam int S4 = 2;
  localparam int S8 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] g4 = '0;
  logic       clr4 = 1'b0;
  logic [3:0] bin4, dl4;
  logic       ch4, rdy4, err4;
  logic [7:0] g8 = '0;
  logic       clr8 = 1'b0;
  logic [7:0] bin8, dl8;
  logic       ch8, rdy8, err8;

  always #5 clk = ~clk;

  gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(S4)) u_dut4 (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_gray      (g4),
    .i_errorClear(clr4),
    .o_binary    (bin4),
    .o_delta     (dl4),
    .o_changed   (ch4),
    .o_ready     (rdy4),
    .o_error     (err4)
  );

  gray_sync_decoder #(.WIDTH(8), .SYNC_STAGES(S8)) u_dut8 (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_gray      (g8),
    .i_errorClear(clr8),
    .o_binary    (bin8),
    .o_delta     (dl8),
    .o_changed   (ch8),
    .o_ready     (rdy8),
    .o_error     (err8)
  );

  int checks = 0;
  int errors = 0;

  int hist4 [4096];
  int hist8 [4096];
  int e = 0;
  int cur4 = 0;
  int cur8 = 0;
  int steps8 = 0;
  int dsum8 = 0;
  bit experr = 1'b0;
  bit hold8 = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  function automatic logic [7:0] to_gray(input int b);
    return 8'((b ^ (b >> 1)) & 255);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_bin4"}, 32'(bin4), 0);
    check({tag, "_dl4"}, 32'(dl4), 0);
    check({tag, "_ch4"}, 32'(ch4), 0);
    check({tag, "_rdy4"}, 32'(rdy4), 0);
    check({tag, "_err4"}, 32'(err4), 0);
    check({tag, "_bin8"}, 32'(bin8), 0);
    check({tag, "_dl8"}, 32'(dl8), 0);
    check({tag, "_ch8"}, 32'(ch8), 0);
    check({tag, "_rdy8"}, 32'(rdy8), 0);
  endtask

  // Reset pulse shorter than a clock cycle, landing mid-cycle.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    #1 rst_n = 1'b1;
    e = 0;
    experr = 1'b0;
    steps8 = 0;
    dsum8 = 0;
  endtask

  task automatic verify(input bit c4);
    int b, d, r;
    bit set;
    if (e <= S4) begin
      b = 0; d = 0; r = 0;
    end else if (e == S4 + 1) begin
      b = hist4[1]; d = 0; r = 0;
    end else begin
      b = hist4[e-S4]; d = (hist4[e-S4] - hist4[e-S4-1]) & 15; r = 1;
      set = $countones(to_gray(hist4[e-S4]) ^ to_gray(hist4[e-S4-1])) > 1;
      experr = set | (experr & ~c4);
    end
    check("bin4", 32'(bin4), 32'(b));
    check("dl4", 32'(dl4), 32'(d));
    check("ch4", 32'(ch4), 32'(d != 0));
    check("rdy4", 32'(rdy4), 32'(r));
`ifdef GRAY_SYNC_DECODER_ERRCHECK_EN
    check("err4", 32'(err4), 32'(experr));
`else
    check("err4", 32'(err4), 0);
`endif
    if (e <= S8) begin
      b = 0; d = 0; r = 0;
    end else if (e == S8 + 1) begin
      b = hist8[1]; d = 0; r = 0;
    end else begin
      b = hist8[e-S8]; d = (hist8[e-S8] - hist8[e-S8-1]) & 255; r = 1;
    end
    check("bin8", 32'(bin8), 32'(b));
    check("dl8", 32'(dl8), 32'(d));
    check("ch8", 32'(ch8), 32'(d != 0));
    check("rdy8", 32'(rdy8), 32'(r));
    check("err8", 32'(err8), 0);
    dsum8 += int'(dl8);
  endtask

  // Present inputs for the next edge, take the edge, then check.
  task automatic cycle(input int nb4, input bit c4);
    cur4 = nb4 & 15;
    g4 = 4'(to_gray(cur4));
    clr4 = c4;
    if (e >= 1 && !hold8 && $urandom_range(1, 0) == 1) begin
      cur8 = (cur8 + 1) & 255;
      steps8++;
    end
    g8 = to_gray(cur8);
    @(posedge clk);
    e++;
    hist4[e] = cur4;
    hist8[e] = cur8;
    #1 verify(c4);
  endtask

  initial begin
    cur8 = int'($urandom_range(255, 0));
    g8 = to_gray(cur8);

    do_reset("rst0");
    for (int i = 0; i < 8; i++) cycle(0, 1'b0);

    do_reset("rst1");
    for (int i = 0; i < 3; i++) cycle(12, 1'b0);
    cycle(13, 1'b0);
    cycle(14, 1'b0);
    cycle(15, 1'b0);
    cycle(0, 1'b0);
    cycle(1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(2, 1'b0);
    for (int i = 0; i < 5; i++) cycle(4, 1'b0);
    cycle(4, 1'b1);
    for (int i = 0; i < 2; i++) cycle(4, 1'b0);
    cycle(6, 1'b0);
    cycle(6, 1'b0);
    cycle(6, 1'b1);
    for (int i = 0; i < 2; i++) cycle(6, 1'b0);
    cycle(6, 1'b1);
    for (int i = 0; i < 2; i++) cycle(6, 1'b0);

    do_reset("rst2");
    for (int i = 0; i < 300; i++) begin
      cycle(cur4 + int'($urandom_range(3, 0)), $urandom_range(7, 0) == 0);
    end
    hold8 = 1'b1;
    for (int i = 0; i < S8 + 2; i++) cycle(cur4, 1'b0);
    check("dsum8", 32'(dsum8 & 255), 32'(steps8 & 255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
